// File: rtl/arp_query_sched.sv
// arp_query_sched
// Round-robin scheduler that shares the single ARP query port of arp_tx
// among NUM_REQ IP-layer requesters. One requester is granted at a time.
// Its IP is presented to arp_tx, and the block waits for the matching reply.
// A timed-out query is re-sent up to MAX_RETRY more times. The outcome is
// returned as a one-hot completion pulse with a resolved/failed flag.
//
// Ports
//   logic_clk, logic_rst_n   clock, asynchronous active-low reset
//   req_valid_in[NUM_REQ]    per-requester resolve request (level)
//   req_ip_in[NUM_REQ*32]    target IP, requester i at [i*32 +: 32]
//   req_ready_out[NUM_REQ]   one-hot accept pulse (GRANT cycle)
//   done_valid_out[NUM_REQ]  one-hot completion pulse (DONE cycle)
//   done_ok_out              1 = resolved, 0 = failed, with done_valid_out
//   trig_arp_qvalid_out      query request toward arp_tx (SEND)
//   trig_arp_ip_out          queried IP, held through SEND/WAIT/DONE
//   trig_arp_qready_in       reply-match pulse from arp_tx
//   arp_tx_done_in           last beat of the arp_tx query frame
//   busy_out                 scheduler not idle
//   fail_cnt_out             saturating count of failed resolutions
//   dbg_state                current FSM state (0 IDLE,1 GRANT,2 SEND,3 WAIT,4 DONE)
//
// Handshake: a requester raises req_valid_in with a stable req_ip_in. The
// request is accepted by the one-cycle req_ready_out pulse. The requester
// drops req_valid_in in the following cycle, and a level still high after
// that is a new request. Every accepted request gets exactly one
// done_valid_out pulse, unless a reset intervenes.
//
// All outputs are flops loaded from values decoded from the next state, so
// each output lines up with the state it belongs to.

module arp_query_sched #(
  parameter int          NUM_REQ        = 4,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd1_250_000,
  parameter int          MAX_RETRY      = 3
) (
  input  logic                   logic_clk,
  input  logic                   logic_rst_n,
  input  logic [NUM_REQ-1:0]     req_valid_in,
  input  logic [NUM_REQ*32-1:0]  req_ip_in,
  output logic [NUM_REQ-1:0]     req_ready_out,
  output logic [NUM_REQ-1:0]     done_valid_out,
  output logic                   done_ok_out,
  output logic                   trig_arp_qvalid_out,
  output logic [31:0]            trig_arp_ip_out,
  input  logic                   trig_arp_qready_in,
  input  logic                   arp_tx_done_in,
  output logic                   busy_out,
  output logic [15:0]            fail_cnt_out,
  output logic [2:0]             dbg_state
);

  localparam int          GW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [31:0] TERM     = TIMEOUT_CYCLES - 32'd1;
  localparam logic [3:0]  MAX_R    = 4'(MAX_RETRY);
  localparam logic [GW-1:0] LAST_RST = GW'(NUM_REQ - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_GRANT = 3'd1,
    S_SEND  = 3'd2,
    S_WAIT  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t          state, next_state;
  logic [GW-1:0]   gnt, last_grant, pick;
  logic            any_req;
  logic [31:0]     ip_q, timer;
  logic [3:0]      retry_cnt;
  logic            hit;
  logic            timer_term, retry_left, ok_next;

  logic [NUM_REQ-1:0] ready_d, done_d;
  logic               ok_d, qvalid_d, busy_d;
  logic [31:0]        ip_d;
  logic [15:0]        fail_d;

  assign dbg_state  = state;
  assign timer_term = (timer == TERM);
  assign retry_left = (retry_cnt < MAX_R);
  // Success outcome if DONE is entered this cycle. In SEND a reply may
  // already have been seen (hit) or coincide with the end of the frame.
  assign ok_next    = (state == S_SEND) ? (hit | trig_arp_qready_in) : trig_arp_qready_in;

  // Round-robin search. The loop runs from the farthest candidate to the
  // nearest, so the last match written is the one nearest last_grant+1.
  always_comb begin : pick_search
    int idx;
    idx     = 0;
    pick    = '0;
    any_req = 1'b0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = (int'(last_grant) + k) % NUM_REQ;
      if (req_valid_in[GW'(idx)]) begin
        pick    = GW'(idx);
        any_req = 1'b1;
      end
    end
  end

  // State register
  always_ff @(posedge logic_clk or negedge logic_rst_n) begin
    if (!logic_rst_n) state <= S_IDLE;
    else              state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (any_req) next_state = S_GRANT;
      S_GRANT: next_state = S_SEND;
      S_SEND:  if (arp_tx_done_in) next_state = (hit | trig_arp_qready_in) ? S_DONE : S_WAIT;
      S_WAIT: begin
        // A reply in the terminal cycle wins over the timeout.
        if (trig_arp_qready_in)  next_state = S_DONE;
        else if (timer_term)     next_state = retry_left ? S_SEND : S_DONE;
      end
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Output decode (values the output flops take for the next cycle)
  always_comb begin
    ready_d  = '0;
    done_d   = '0;
    ok_d     = 1'b0;
    qvalid_d = (next_state == S_SEND);
    busy_d   = (next_state != S_IDLE);
    ip_d     = '0;
    fail_d   = fail_cnt_out;
    // GRANT is entered only from IDLE, so the grant index is the current pick.
    if (next_state == S_GRANT) ready_d[pick] = 1'b1;
    if (next_state == S_DONE) begin
      done_d[gnt] = 1'b1;
      ok_d        = ok_next;
      if (!ok_next && (fail_cnt_out != 16'hFFFF)) fail_d = fail_cnt_out + 16'd1;
    end
    // arp_tx matches replies against this IP, so it stays up until IDLE.
    if ((next_state == S_SEND) || (next_state == S_WAIT) || (next_state == S_DONE))
      ip_d = ip_q;
  end

  // Output registers
  always_ff @(posedge logic_clk or negedge logic_rst_n) begin
    if (!logic_rst_n) begin
      req_ready_out       <= '0;
      done_valid_out      <= '0;
      done_ok_out         <= 1'b0;
      trig_arp_qvalid_out <= 1'b0;
      trig_arp_ip_out     <= '0;
      busy_out            <= 1'b0;
      fail_cnt_out        <= '0;
    end else begin
      req_ready_out       <= ready_d;
      done_valid_out      <= done_d;
      done_ok_out         <= ok_d;
      trig_arp_qvalid_out <= qvalid_d;
      trig_arp_ip_out     <= ip_d;
      busy_out            <= busy_d;
      fail_cnt_out        <= fail_d;
    end
  end

  // Request bookkeeping, reply tracking and timeout counting
  always_ff @(posedge logic_clk or negedge logic_rst_n) begin
    if (!logic_rst_n) begin
      gnt        <= '0;
      last_grant <= LAST_RST;
      ip_q       <= '0;
      retry_cnt  <= '0;
      timer      <= '0;
      hit        <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (any_req) begin
            gnt       <= pick;
            ip_q      <= req_ip_in[32*int'(pick) +: 32];
            retry_cnt <= '0;
          end
        end
        S_GRANT: last_grant <= gnt;
        S_SEND: begin
          if (trig_arp_qready_in) hit <= 1'b1;
          if (arp_tx_done_in)     timer <= '0;
        end
        S_WAIT: begin
          timer <= timer + 32'd1;
          if (!trig_arp_qready_in && timer_term && retry_left)
            retry_cnt <= retry_cnt + 4'd1;
        end
        default: ;
      endcase
      // Every SEND phase starts with no reply seen.
      if ((next_state == S_SEND) && (state != S_SEND)) hit <= 1'b0;
    end
  end

endmodule

// File: tb/tb_arp_query_sched.sv
// Testbench for arp_query_sched: scenario tasks with inline checks against a
// rule-level model (round-robin search, fixed retry/timeout arithmetic,
// saturating failure count).
module tb_arp_query_sched;

  localparam int NUM_REQ = 4;
  localparam int T       = 64;
  localparam int MR      = 2;

  logic                  clk;
  logic                  rst_n;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ*32-1:0] req_ip;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ-1:0]    done_valid;
  logic                  done_ok;
  logic                  qvalid;
  logic [31:0]           trig_ip;
  logic                  qready;
  logic                  tx_done;
  logic                  busy;
  logic [15:0]           fail_cnt;
  logic [2:0]            dbg_state;

  int n_cmp = 0;
  int n_bad = 0;
  int model_last;
  int model_fail;
  logic [31:0] exp_q[$];

  arp_query_sched #(
    .NUM_REQ(NUM_REQ), .TIMEOUT_CYCLES(32'(T)), .MAX_RETRY(MR)
  ) dut (
    .logic_clk(clk), .logic_rst_n(rst_n),
    .req_valid_in(req_valid), .req_ip_in(req_ip),
    .req_ready_out(req_ready), .done_valid_out(done_valid), .done_ok_out(done_ok),
    .trig_arp_qvalid_out(qvalid), .trig_arp_ip_out(trig_ip),
    .trig_arp_qready_in(qready), .arp_tx_done_in(tx_done),
    .busy_out(busy), .fail_cnt_out(fail_cnt), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- model helpers ----------------
  function automatic int next_grant(input logic [NUM_REQ-1:0] v, input int last);
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (v[(last + k) % NUM_REQ]) return (last + k) % NUM_REQ;
    end
    return -1;
  endfunction

  function automatic logic [NUM_REQ-1:0] onehot(input int i);
    logic [NUM_REQ-1:0] v;
    v = '0;
    if (i >= 0) v[i] = 1'b1;
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clk);
  endtask

  // Steps until a ready pulse is seen (bounded); rdy stays 0 on expiry.
  task automatic wait_ready(output logic [NUM_REQ-1:0] rdy, output int steps);
    steps = 0;
    rdy   = '0;
    while (steps < 20) begin
      step();
      steps++;
      if (req_ready != '0) begin
        rdy = req_ready;
        break;
      end
    end
  endtask

  // Called at the GRANT negedge; returns at the negedge of the DONE cycle.
  // mode 0: tx_done and reply together; 1: reply early in SEND; 2: reply in WAIT.
  task automatic drive_reply(input int mode, input int dly,
                             output logic [31:0] ip_seen, output logic qv_seen,
                             output logic [NUM_REQ-1:0] dv, output logic ok);
    step();
    ip_seen = trig_ip;
    qv_seen = qvalid;
    case (mode)
      0: begin tx_done = 1; qready = 1; step(); tx_done = 0; qready = 0; end
      1: begin
        qready = 1; step(); qready = 0;
        repeat (dly) step();
        tx_done = 1; step(); tx_done = 0;
      end
      default: begin
        tx_done = 1; step(); tx_done = 0;
        repeat (dly) step();
        qready = 1; step(); qready = 0;
      end
    endcase
    dv = done_valid;
    ok = done_ok;
  endtask

  // Called at the GRANT negedge; never replies. Counts SEND phases and how
  // many tx_done-to-next-event gaps differ from a full WAIT (T cycles) + 1.
  task automatic drive_no_reply(output int sends, output int gaps_bad,
                                output logic [NUM_REQ-1:0] dv, output logic ok,
                                output logic to);
    int k;
    logic fin;
    sends = 0; gaps_bad = 0; dv = '0; ok = 1'bx; to = 0; fin = 0;
    step();
    while (!fin && !to && sends < 20) begin
      if (qvalid) sends++;
      repeat ($urandom_range(0, 2)) step();
      tx_done = 1; step(); tx_done = 0;
      k = 1;
      while (!qvalid && (done_valid == '0) && k < T + 8) begin
        step();
        k++;
      end
      if (!qvalid && (done_valid == '0)) to = 1;
      if (k != T + 1) gaps_bad++;
      if (done_valid != '0) begin
        fin = 1;
        dv  = done_valid;
        ok  = done_ok;
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 0; req_valid = '0; req_ip = '0; qready = 0; tx_done = 0;
    repeat (3) step();
    n_cmp++; if (req_ready !== '0)  begin n_bad++; $display("FAIL rst_ready got %b want 0", req_ready); end
    n_cmp++; if (done_valid !== '0) begin n_bad++; $display("FAIL rst_done got %b want 0", done_valid); end
    n_cmp++; if (done_ok !== 1'b0)  begin n_bad++; $display("FAIL rst_ok got %b want 0", done_ok); end
    n_cmp++; if (qvalid !== 1'b0)   begin n_bad++; $display("FAIL rst_qvalid got %b want 0", qvalid); end
    n_cmp++; if (trig_ip !== 32'd0) begin n_bad++; $display("FAIL rst_ip got %h want 0", trig_ip); end
    n_cmp++; if (busy !== 1'b0)     begin n_bad++; $display("FAIL rst_busy got %b want 0", busy); end
    n_cmp++; if (fail_cnt !== 16'd0) begin n_bad++; $display("FAIL rst_fail got %h want 0", fail_cnt); end
    n_cmp++; if (dbg_state !== 3'd0) begin n_bad++; $display("FAIL rst_state got %0d want 0", dbg_state); end
    rst_n = 1;
    model_last = NUM_REQ - 1;
    model_fail = 0;
  endtask

  task automatic test_round_robin();
    logic [NUM_REQ-1:0] rdy, dv;
    logic [31:0] ip_seen, exp_ip;
    logic qv, ok;
    int steps, g;
    for (int i = 0; i < NUM_REQ; i++) req_ip[i*32 +: 32] = $urandom;
    req_valid = '1;
    for (int n = 0; n < 5; n++) begin
      g = next_grant(req_valid, model_last);
      exp_q.push_back(req_ip[g*32 +: 32]);
      wait_ready(rdy, steps);
      n_cmp++; if (rdy !== onehot(g)) begin n_bad++; $display("FAIL rr_grant%0d got %b want %b", n, rdy, onehot(g)); end
      n_cmp++; if (steps !== ((n == 0) ? 1 : 2)) begin n_bad++; $display("FAIL rr_gap%0d got %0d want %0d", n, steps, (n == 0) ? 1 : 2); end
      req_valid[g] = 1'b0;
      model_last = g;
      drive_reply($urandom_range(0, 2), $urandom_range(0, 4), ip_seen, qv, dv, ok);
      exp_ip = exp_q.pop_front();
      n_cmp++; if (ip_seen !== exp_ip) begin n_bad++; $display("FAIL rr_ip%0d got %h want %h", n, ip_seen, exp_ip); end
      n_cmp++; if (qv !== 1'b1) begin n_bad++; $display("FAIL rr_qvalid%0d got %b want 1", n, qv); end
      n_cmp++; if (dv !== onehot(g) || ok !== 1'b1) begin n_bad++; $display("FAIL rr_done%0d got %b ok %b want %b ok 1", n, dv, ok, onehot(g)); end
      if (n < 4) req_valid[g] = 1'b1;
      else       req_valid = '0;
    end
  endtask

  task automatic test_single();
    logic [NUM_REQ-1:0] rdy;
    int steps, bad;
    step();
    req_ip[2*32 +: 32] = 32'hC0A8_0001;
    req_valid[2] = 1'b1;
    wait_ready(rdy, steps);
    n_cmp++; if (rdy !== 4'b0100) begin n_bad++; $display("FAIL single_ready got %b want 0100", rdy); end
    req_valid[2] = 1'b0;
    model_last = 2;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (qvalid !== 1'b1 || trig_ip !== 32'hC0A8_0001) bad++;
    end
    n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL single_send got %0d bad cycles want 0", bad); end
    tx_done = 1; step(); tx_done = 0;
    n_cmp++; if (qvalid !== 1'b0) begin n_bad++; $display("FAIL single_qv_low got %b want 0", qvalid); end
    bad = 0;
    for (int i = 0; i < 49; i++) begin
      if (trig_ip !== 32'hC0A8_0001 || done_valid !== '0 || qvalid !== 1'b0 || busy !== 1'b1) bad++;
      step();
    end
    n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL single_hold got %0d bad cycles want 0", bad); end
    qready = 1; step(); qready = 0;
    n_cmp++; if (done_valid !== 4'b0100 || done_ok !== 1'b1) begin n_bad++; $display("FAIL single_done got %b ok %b want 0100 ok 1", done_valid, done_ok); end
    step();
    n_cmp++; if (done_valid !== '0 || busy !== 1'b0 || trig_ip !== 32'd0) begin n_bad++; $display("FAIL single_idle got dv %b busy %b ip %h want 0 0 0", done_valid, busy, trig_ip); end
  endtask

  task automatic test_timeout();
    logic [NUM_REQ-1:0] rdy, dv;
    logic ok, to;
    int steps, r, sends, gb;
    r = $urandom_range(0, NUM_REQ - 1);
    req_ip[r*32 +: 32] = $urandom;
    req_valid[r] = 1'b1;
    wait_ready(rdy, steps);
    n_cmp++; if (rdy !== onehot(next_grant(onehot(r), model_last))) begin n_bad++; $display("FAIL to_ready got %b want %b", rdy, onehot(r)); end
    req_valid[r] = 1'b0;
    model_last = r;
    drive_no_reply(sends, gb, dv, ok, to);
    model_fail = model_fail + 1;
    n_cmp++; if (to !== 1'b0) begin n_bad++; $display("FAIL to_bound got expired want event"); end
    n_cmp++; if (sends != MR + 1) begin n_bad++; $display("FAIL to_sends got %0d want %0d", sends, MR + 1); end
    n_cmp++; if (gb != 0) begin n_bad++; $display("FAIL to_gaps got %0d wrong want 0", gb); end
    n_cmp++; if (dv !== onehot(r) || ok !== 1'b0) begin n_bad++; $display("FAIL to_done got %b ok %b want %b ok 0", dv, ok, onehot(r)); end
    n_cmp++; if (fail_cnt !== 16'(model_fail)) begin n_bad++; $display("FAIL to_failcnt got %0d want %0d", fail_cnt, model_fail); end
  endtask

  task automatic test_collision();
    logic [NUM_REQ-1:0] rdy;
    int steps, r;
    step();
    r = $urandom_range(0, NUM_REQ - 1);
    req_valid[r] = 1'b1;
    wait_ready(rdy, steps);
    req_valid[r] = 1'b0;
    model_last = r;
    step();
    tx_done = 1; step(); tx_done = 0;
    repeat (T - 1) step();
    // This cycle is the last WAIT cycle of the first attempt.
    n_cmp++; if (qvalid !== 1'b0 || done_valid !== '0) begin n_bad++; $display("FAIL col_pre got qv %b dv %b want 0 0", qvalid, done_valid); end
    qready = 1; step(); qready = 0;
    n_cmp++; if (done_valid !== onehot(r) || done_ok !== 1'b1 || qvalid !== 1'b0) begin n_bad++; $display("FAIL col_done got %b ok %b qv %b want %b ok 1 qv 0", done_valid, done_ok, qvalid, onehot(r)); end
    n_cmp++; if (fail_cnt !== 16'(model_fail)) begin n_bad++; $display("FAIL col_failcnt got %0d want %0d", fail_cnt, model_fail); end
    step();
    n_cmp++; if (busy !== 1'b0 || qvalid !== 1'b0) begin n_bad++; $display("FAIL col_idle got busy %b qv %b want 0 0", busy, qvalid); end
  endtask

  task automatic test_reset_mid_wait();
    logic [NUM_REQ-1:0] rdy, dv;
    logic [31:0] ip_seen;
    logic qv, ok;
    int steps, r, bad;
    r = $urandom_range(0, NUM_REQ - 1);
    req_valid[r] = 1'b1;
    wait_ready(rdy, steps);
    req_valid[r] = 1'b0;
    step();
    tx_done = 1; step(); tx_done = 0;
    repeat (5) step();
    #2 rst_n = 0;
    #1;
    n_cmp++; if (busy !== 1'b0 || qvalid !== 1'b0 || trig_ip !== 32'd0 || dbg_state !== 3'd0) begin n_bad++; $display("FAIL mrst_outs got busy %b qv %b ip %h st %0d want 0", busy, qvalid, trig_ip, dbg_state); end
    n_cmp++; if (req_ready !== '0 || done_valid !== '0 || done_ok !== 1'b0 || fail_cnt !== 16'd0) begin n_bad++; $display("FAIL mrst_outs2 got rdy %b dv %b ok %b fc %0d want 0", req_ready, done_valid, done_ok, fail_cnt); end
    model_last = NUM_REQ - 1;
    model_fail = 0;
    bad = 0;
    repeat (3) begin step(); if (done_valid !== '0) bad++; end
    rst_n = 1;
    repeat (2) begin step(); if (done_valid !== '0) bad++; end
    n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL mrst_nodone got %0d pulses want 0", bad); end
    req_valid = '1;
    wait_ready(rdy, steps);
    n_cmp++; if (rdy !== onehot(next_grant('1, model_last))) begin n_bad++; $display("FAIL mrst_first got %b want %b", rdy, onehot(0)); end
    req_valid = '0;
    model_last = 0;
    drive_reply(0, 0, ip_seen, qv, dv, ok);
    n_cmp++; if (dv !== onehot(0) || ok !== 1'b1) begin n_bad++; $display("FAIL mrst_done got %b ok %b want 0001 ok 1", dv, ok); end
  endtask

  task automatic test_saturation();
    logic [NUM_REQ-1:0] rdy, dv;
    logic ok, to;
    int steps, r, sends, gb;
    step();
    force dut.fail_cnt_out = 16'hFFFD;
    #1 release dut.fail_cnt_out;
    model_fail = 16'hFFFD;
    for (int n = 0; n < 3; n++) begin
      r = $urandom_range(0, NUM_REQ - 1);
      req_valid[r] = 1'b1;
      wait_ready(rdy, steps);
      req_valid[r] = 1'b0;
      drive_no_reply(sends, gb, dv, ok, to);
      model_fail = (model_fail < 16'hFFFF) ? model_fail + 1 : model_fail;
      n_cmp++; if (dv !== onehot(r) || ok !== 1'b0) begin n_bad++; $display("FAIL sat_done%0d got %b ok %b want %b ok 0", n, dv, ok, onehot(r)); end
      n_cmp++; if (fail_cnt !== 16'(model_fail)) begin n_bad++; $display("FAIL sat_cnt%0d got %h want %h", n, fail_cnt, 16'(model_fail)); end
    end
    step();
    n_cmp++; if (fail_cnt !== 16'hFFFF) begin n_bad++; $display("FAIL sat_hold got %h want ffff", fail_cnt); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_round_robin();
    test_single();
    test_timeout();
    test_collision();
    test_reset_mid_wait();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
